// File: rtl/ram_fifo_if.sv
// Bundle between the FIFO controller, its producer/consumer stages and the
// dual-port RAM it drives (port A writes, port B reads).
interface ram_fifo_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              init_done;
  logic              wen_a;
  logic              ren_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] datain_a;
  logic              wen_b;
  logic              ren_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] dataout_b;

  modport slave (
    input  wr_en, wr_data, rd_en, dataout_b,
    output rd_data, rd_valid, full, empty, count, overflow, underflow,
           init_done, wen_a, ren_a, addr_a, datain_a, wen_b, ren_b, addr_b
  );

  modport master (
    output wr_en, wr_data, rd_en, dataout_b,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow,
           init_done, wen_a, ren_a, addr_a, datain_a, wen_b, ren_b, addr_b
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a dual-port RAM: zero-sweeps the RAM after reset,
// then maps push/pop strobes onto write port A and read port B.
module ram_fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  ram_fifo_if.slave bus
);
  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] wptr_reg;
  logic [ADDR_W-1:0] rptr_reg;
  logic [ADDR_W-1:0] init_cnt_reg;
  logic [ADDR_W:0]   count_reg;
  logic              rd_valid_reg;
  logic              overflow_reg;
  logic              underflow_reg;

  logic run;
  logic sweeping;
  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;

  assign run      = (state_reg == RUN);
  assign sweeping = (state_reg == INIT);
  // Outside RUN the queue reports both full and empty so nothing is accepted.
  assign full     = !run || (count_reg == DEPTH_CNT);
  assign empty    = !run || (count_reg == '0);
  assign push_ok  = run && bus.wr_en && !full;
  assign pop_ok   = run && bus.rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      init_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: state_reg <= INIT;
        INIT: begin
          init_cnt_reg <= init_cnt_reg + 1'b1;
          if (init_cnt_reg == LAST_ADDR)
            state_reg <= RUN;
        end
        RUN:     state_reg <= RUN;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_ok)
        wptr_reg <= wptr_reg + 1'b1;
      if (pop_ok)
        rptr_reg <= rptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      rd_valid_reg  <= pop_ok;
      overflow_reg  <= run && bus.wr_en && full;
      underflow_reg <= run && bus.rd_en && empty;
    end
  end

  assign bus.wen_a    = sweeping || push_ok;
  assign bus.ren_a    = 1'b0;
  assign bus.addr_a   = sweeping ? init_cnt_reg : wptr_reg;
  assign bus.datain_a = sweeping ? '0 : bus.wr_data;
  assign bus.wen_b    = 1'b0;
  assign bus.ren_b    = pop_ok;
  assign bus.addr_b   = rptr_reg;

  assign bus.rd_data   = bus.dataout_b;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
  assign bus.init_done = run;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 16x4 dual-port RAM
// attached; inputs change just after the rising edge, outputs are checked
// on the falling edge.
module tb_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ram_fifo_if #(.DATA_W(4), .ADDR_W(4)) bus ();
  ram_fifo_ctrl #(.DATA_W(4), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [3:0] mem [16];
  always @(posedge clk) begin
    if (bus.wen_a) mem[bus.addr_a] <= bus.datain_a;
    if (bus.ren_b) bus.dataout_b <= mem[bus.addr_b];
  end

  typedef struct {
    logic       we;
    logic [3:0] wd;
    logic       re;
    logic       wen;
    logic       ren;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       rv;
    logic [3:0] rdat;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wd, input logic re);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Expects rst to have just been released after a rising edge.
  task automatic init_seq();
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 4'h5;
    @(negedge clk);
    check("idle_wen_a", bus.wen_a, 0);
    check("idle_ren_b", bus.ren_b, 0);
    check("idle_full", bus.full, 1);
    check("idle_empty", bus.empty, 1);
    check("idle_init_done", bus.init_done, 0);
    adv();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin bus.wr_en = 1'b0; bus.rd_en = 1'b0; end
      @(negedge clk);
      check("init_wen_a", bus.wen_a, 1);
      check("init_addr_a", bus.addr_a, i);
      check("init_datain_a", bus.datain_a, 0);
      check("init_ren_b", bus.ren_b, 0);
      check("init_full", bus.full, 1);
      check("init_empty", bus.empty, 1);
      check("init_ovf", bus.overflow, 0);
      check("init_unf", bus.underflow, 0);
      adv();
    end
    @(negedge clk);
    check("run_init_done", bus.init_done, 1);
    check("run_empty", bus.empty, 1);
    check("run_full", bus.full, 0);
    check("run_count", bus.count, 0);
    check("run_wen_a", bus.wen_a, 0);
    check("run_ovf", bus.overflow, 0);
    check("run_unf", bus.underflow, 0);
    adv();
    $display("init sequence complete at %0t", $time);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                we  wd    re  wen ren cnt full empty ovf unf rv rdat
    tbl[0] = '{1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[1] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    tbl[2] = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[3] = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[4] = '{1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[5] = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[6] = '{1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[7] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3};

    bus.wr_en = 1'b0; bus.wr_data = 4'h0; bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", bus.count, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_init_done", bus.init_done, 0);
    check("rst_wen_a", bus.wen_a, 0);
    check("rst_ren_b", bus.ren_b, 0);
    check("rst_ren_a", bus.ren_a, 0);
    check("rst_wen_b", bus.wen_b, 0);
    rst = 1'b0;
    init_seq();

    // Fill to full, then one rejected push.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      check("push_wen_a", bus.wen_a, 1);
      check("push_addr_a", bus.addr_a, i);
      check("push_datain_a", bus.datain_a, i);
      check("push_count", bus.count, i);
      check("push_full", bus.full, 0);
      adv();
    end
    drive(1'b1, 4'hA, 1'b0);
    check("ovf_full", bus.full, 1);
    check("ovf_count", bus.count, 16);
    check("ovf_wen_a", bus.wen_a, 0);
    adv();
    drive(1'b0, 4'h0, 1'b0);
    check("ovf_pulse", bus.overflow, 1);
    check("ovf_count_hold", bus.count, 16);
    adv();
    drive(1'b0, 4'h0, 1'b0);
    check("ovf_pulse_end", bus.overflow, 0);
    adv();
    $display("push phase done, count=%0d", bus.count);

    // Drain, then one rejected pop.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      check("pop_ren_b", bus.ren_b, 1);
      check("pop_addr_b", bus.addr_b, i);
      check("pop_count", bus.count, 16 - i);
      if (i > 0) begin
        check("pop_rd_valid", bus.rd_valid, 1);
        check("pop_rd_data", bus.rd_data, i - 1);
      end
      adv();
    end
    drive(1'b0, 4'h0, 1'b1);
    check("unf_rd_valid", bus.rd_valid, 1);
    check("unf_rd_data", bus.rd_data, 15);
    check("unf_empty", bus.empty, 1);
    check("unf_ren_b", bus.ren_b, 0);
    adv();
    drive(1'b0, 4'h0, 1'b0);
    check("unf_pulse", bus.underflow, 1);
    check("unf_rd_valid_end", bus.rd_valid, 0);
    adv();
    $display("pop phase done, empty=%0d", bus.empty);

    // Move both pointers to 10, then straddle the wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      adv();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      adv();
    end
    drive(1'b0, 4'h0, 1'b0);
    check("pre_wrap_rd_data", bus.rd_data, 9);
    check("pre_wrap_empty", bus.empty, 1);
    adv();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 4'(i + 1), 1'b0);
      check("wrap_wen_a", bus.wen_a, 1);
      check("wrap_addr_a", bus.addr_a, (10 + i) % 16);
      adv();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      check("wrap_addr_b", bus.addr_b, (10 + i) % 16);
      if (i > 0) check("wrap_rd_data", bus.rd_data, i);
      adv();
    end
    drive(1'b0, 4'h0, 1'b0);
    check("wrap_rd_data_last", bus.rd_data, 12);
    check("wrap_empty", bus.empty, 1);
    adv();
    $display("wrap phase done");

    // Simultaneous push/pop at empty and mid-level.
    for (int v = 0; v < 8; v++) begin
      drive(tbl[v].we, tbl[v].wd, tbl[v].re);
      $display("vec %0d: we=%0d wd=%0d re=%0d count=%0d", v, tbl[v].we, tbl[v].wd, tbl[v].re, bus.count);
      check("vec_wen_a", bus.wen_a, tbl[v].wen);
      check("vec_ren_b", bus.ren_b, tbl[v].ren);
      check("vec_count", bus.count, tbl[v].cnt);
      check("vec_full", bus.full, tbl[v].full);
      check("vec_empty", bus.empty, tbl[v].empty);
      check("vec_ovf", bus.overflow, tbl[v].ovf);
      check("vec_unf", bus.underflow, tbl[v].unf);
      check("vec_rd_valid", bus.rd_valid, tbl[v].rv);
      if (tbl[v].rv) check("vec_rd_data", bus.rd_data, tbl[v].rdat);
      adv();
    end

    // Top up to full (queue holds 4..8, then 9..15,0..3), then push+pop.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 4'(9 + i), 1'b0);
      check("fill_count", bus.count, 5 + i);
      adv();
    end
    drive(1'b1, 4'hE, 1'b1);
    check("pp_full_full", bus.full, 1);
    check("pp_full_count", bus.count, 16);
    check("pp_full_wen_a", bus.wen_a, 0);
    check("pp_full_ren_b", bus.ren_b, 1);
    adv();
    drive(1'b0, 4'h0, 1'b0);
    check("pp_full_count_after", bus.count, 15);
    check("pp_full_ovf", bus.overflow, 1);
    check("pp_full_rd_data", bus.rd_data, 4);
    adv();
    $display("full push+pop done, count=%0d", bus.count);

    // Pop down to 7 with the last pop's data just returning, then reset.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'h0, 1'b1);
      check("pre_rst_count", bus.count, 15 - i);
      if (i > 0) check("pre_rst_rd_data", bus.rd_data, 4 + i);
      adv();
    end
    bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    #1;
    check("mid_count", bus.count, 7);
    check("mid_rd_valid", bus.rd_valid, 1);
    check("mid_rd_data", bus.rd_data, 12);
    check("mid_ren_b", bus.ren_b, 1);
    rst = 1'b1;
    #1;
    check("arst_count", bus.count, 0);
    check("arst_rd_valid", bus.rd_valid, 0);
    check("arst_wen_a", bus.wen_a, 0);
    check("arst_ren_b", bus.ren_b, 0);
    check("arst_empty", bus.empty, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    init_seq();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
